// File: rtl/maf_dot_product_sequencer.sv
// Valid/ready sequencer that drives an external MAF to compute C +/- sum(A_i*B_i).
// Optional macro MAF_SEQ_NAN_STICKY_EN: once the accumulator holds NaN it stays NaN.
module maf_dot_product_sequencer #(
  parameter int unsigned size_mantissa        = 24,
  parameter int unsigned size_exponent        = 8,
  parameter int unsigned size_exception_field = 2,
  parameter int unsigned size                 = size_exponent + size_mantissa +
                                                size_exception_field,
  parameter int unsigned size_len             = 8,
  parameter int unsigned MAF_LATENCY          = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [size_len-1:0] len,
  input  logic [size-1:0]     c_init,
  input  logic                sub,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [size-1:0]     a_i,
  input  logic [size-1:0]     b_i,
  output logic [size-1:0]     maf_a_o,
  output logic [size-1:0]     maf_b_o,
  output logic [size-1:0]     maf_c_o,
  output logic                maf_sub_o,
  output logic [1:0]          maf_conversion_o,
  input  logic [size-1:0]     maf_result_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [size-1:0]     result_o,
  output logic                busy
);

  localparam int unsigned LatW = (MAF_LATENCY > 0) ? $clog2(MAF_LATENCY + 1) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [size-1:0]     acc_q, acc_d;
  logic [size_len-1:0] cnt_q, cnt_d;
  logic                sub_q, sub_d;
  logic [LatW-1:0]     lat_q, lat_d;
  logic [size-1:0]     acc_next;
  logic                capture;

`ifdef MAF_SEQ_NAN_STICKY_EN
  logic acc_is_nan;
  assign acc_is_nan = (acc_q[size-1 -: size_exception_field] == {size_exception_field{1'b1}});
  assign acc_next   = acc_is_nan ? acc_q : maf_result_i;
`else
  assign acc_next = maf_result_i;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    lat_d   = lat_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = c_init;
          cnt_d   = len;
          sub_d   = sub;
          state_d = (len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (in_valid) begin
          if (MAF_LATENCY == 0) begin
            capture = 1'b1;
          end else begin
            lat_d   = LatW'(MAF_LATENCY);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        lat_d = lat_q - 1'b1;
        if (lat_q == LatW'(1)) capture = 1'b1;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A capture consumes one pair regardless of which state produced it.
    if (capture) begin
      acc_d   = acc_next;
      cnt_d   = cnt_q - 1'b1;
      state_d = (cnt_q == size_len'(1)) ? StDone : StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      lat_q   <= lat_d;
    end
  end

  generate
    if (MAF_LATENCY == 0) begin : g_comb_operands
      // Gated so the MAF sees zeros whenever no pair can be accepted.
      assign maf_a_o = in_ready ? a_i : '0;
      assign maf_b_o = in_ready ? b_i : '0;
    end else begin : g_reg_operands
      logic [size-1:0] a_q, b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (state_q == StRun && in_valid) begin
          a_q <= a_i;
          b_q <= b_i;
        end
      end
      assign maf_a_o = a_q;
      assign maf_b_o = b_q;
    end
  endgenerate

  assign in_ready         = (state_q == StRun);
  assign out_valid        = (state_q == StDone);
  assign busy             = (state_q != StIdle);
  assign result_o         = acc_q;
  assign maf_c_o          = acc_q;
  assign maf_sub_o        = sub_q;
  assign maf_conversion_o = 2'b00;

endmodule

// File: tb/tb_maf_dot_product_sequencer.sv
// Directed bench: two sequencer instances (MAF latency 0 and 3) against a lookup MAF model.
module tb_maf_dot_product_sequencer;

  localparam logic [33:0] ZERO  = {2'b00, 1'b0, 8'h00, 23'h000000};
  localparam logic [33:0] ONE   = {2'b01, 1'b0, 8'h7F, 23'h000000};
  localparam logic [33:0] TWO   = {2'b01, 1'b0, 8'h80, 23'h000000};
  localparam logic [33:0] THREE = {2'b01, 1'b0, 8'h80, 23'h400000};
  localparam logic [33:0] FIVE  = {2'b01, 1'b0, 8'h81, 23'h200000};
  localparam logic [33:0] SEVEN = {2'b01, 1'b0, 8'h81, 23'h600000};
  localparam logic [33:0] QNAN  = {2'b11, 1'b0, 8'hFF, 23'h400000};
  localparam logic [33:0] JUNK  = {2'b01, 1'b1, 8'h55, 23'h055555};

  logic        clk, rst, sub, out_ready;
  logic [7:0]  len;
  logic [33:0] c_init, a, b;

  logic        start0, in_valid0, in_ready0, maf_sub0, out_valid0, busy0;
  logic [33:0] maf_a0, maf_b0, maf_c0, res0, result0;
  logic [1:0]  conv0;
  logic        start3, in_valid3, in_ready3, maf_sub3, out_valid3, busy3;
  logic [33:0] maf_a3, maf_b3, maf_c3, res3, result3;
  logic [1:0]  conv3;

  logic        force_en;
  logic [33:0] force_val;
  int          vecs, errs;
  logic [7:0]  rdy_hist;

  maf_dot_product_sequencer #(.MAF_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .len(len), .c_init(c_init), .sub(sub),
    .in_valid(in_valid0), .in_ready(in_ready0), .a_i(a), .b_i(b),
    .maf_a_o(maf_a0), .maf_b_o(maf_b0), .maf_c_o(maf_c0), .maf_sub_o(maf_sub0),
    .maf_conversion_o(conv0), .maf_result_i(res0), .out_valid(out_valid0),
    .out_ready(out_ready), .result_o(result0), .busy(busy0)
  );

  maf_dot_product_sequencer #(.MAF_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .len(len), .c_init(c_init), .sub(sub),
    .in_valid(in_valid3), .in_ready(in_ready3), .a_i(a), .b_i(b),
    .maf_a_o(maf_a3), .maf_b_o(maf_b3), .maf_c_o(maf_c3), .maf_sub_o(maf_sub3),
    .maf_conversion_o(conv3), .maf_result_i(res3), .out_valid(out_valid3),
    .out_ready(out_ready), .result_o(result3), .busy(busy3)
  );

  // Lookup MAF: only the operand combinations the bench uses give meaningful sums.
  function automatic logic [33:0] maf_fn(input logic [33:0] fa, input logic [33:0] fb,
                                         input logic [33:0] fc, input logic fs);
    if (fa == ONE && fb == TWO && fc == ZERO && !fs) return TWO;
    if (fa == THREE && fb == ONE && fc == TWO && !fs) return FIVE;
    if (fa == ONE && fb == ONE && fc == ONE && fs) return ZERO;
    return JUNK;
  endfunction

  always_comb res0 = force_en ? force_val : maf_fn(maf_a0, maf_b0, maf_c0, maf_sub0);
  always_comb res3 = maf_fn(maf_a3, maf_b3, maf_c3, maf_sub3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vecs = 0; errs = 0;
    rst = 1'b1; sub = 1'b0; out_ready = 1'b0; len = 8'd2; c_init = ONE; a = '0; b = '0;
    start0 = 1'b1; in_valid0 = 1'b0; start3 = 1'b0; in_valid3 = 1'b0;
    force_en = 1'b0; force_val = '0;

    // Reset with start held high, then idle.
    tick(); tick(); tick();
    rst = 1'b0; start0 = 1'b0;
    repeat (5) tick();
    chk("rst_busy0", busy0, 0);
    chk("rst_in_ready0", in_ready0, 0);
    chk("rst_out_valid0", out_valid0, 0);
    chk("rst_result0", result0, 0);
    chk("rst_maf_a0", maf_a0, 0);
    chk("rst_maf_b0", maf_b0, 0);
    chk("rst_maf_c0", maf_c0, 0);
    chk("rst_maf_sub0", maf_sub0, 0);
    chk("rst_conv0", conv0, 0);
    chk("rst_busy3", busy3, 0);
    chk("rst_maf_a3", maf_a3, 0);
    chk("rst_result3", result3, 0);

    // Two-pair dot product, latency 0.
    c_init = ZERO; len = 8'd2; sub = 1'b0; start0 = 1'b1;
    tick();
    start0 = 1'b0; a = ONE; b = TWO; in_valid0 = 1'b1;
    #1;
    chk("l0_busy", busy0, 1);
    chk("l0_in_ready_p1", in_ready0, 1);
    chk("l0_maf_a_p1", maf_a0, ONE);
    chk("l0_maf_c_init", maf_c0, ZERO);
    tick();
    a = THREE; b = ONE;
    #1;
    chk("l0_maf_c_p2", maf_c0, TWO);
    chk("l0_in_ready_p2", in_ready0, 1);
    chk("l0_out_valid_early", out_valid0, 0);
    tick();
    in_valid0 = 1'b0;
    #1;
    chk("l0_out_valid", out_valid0, 1);
    chk("l0_result", result0, FIVE);
    chk("l0_in_ready_done", in_ready0, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("l0_idle_busy", busy0, 0);
    chk("l0_idle_out_valid", out_valid0, 0);

    // Same stimulus, latency 3, in_valid held high.
    start3 = 1'b1;
    tick();
    start3 = 1'b0; a = ONE; b = TWO; in_valid3 = 1'b1;
    rdy_hist = '0;
    for (int i = 0; i < 8; i++) begin
      #1;
      rdy_hist[7-i] = in_ready3;
      if (i == 1) begin
        chk("l3_maf_a_held", maf_a3, ONE);
        a = THREE; b = ONE;
      end
      if (i == 4) chk("l3_maf_c_p2", maf_c3, TWO);
      if (i == 5) begin
        chk("l3_maf_b_p2", maf_b3, ONE);
        in_valid3 = 1'b0;
      end
      if (i == 7) chk("l3_out_valid_early", out_valid3, 0);
      tick();
    end
    chk("l3_ready_pattern", rdy_hist, 8'b1000_1000);
    chk("l3_out_valid", out_valid3, 1);
    chk("l3_result", result3, FIVE);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("l3_idle_busy", busy3, 0);

    // len=0 goes straight to DONE; result holds while out_ready is low.
    c_init = THREE; len = 8'd0; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    #1;
    chk("z_out_valid", out_valid0, 1);
    chk("z_result", result0, THREE);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        c_init = ONE; len = 8'd2; start0 = 1'b1;
      end
      tick();
      start0 = 1'b0;
      #1;
      chk("z_hold_result", result0, THREE);
      chk("z_hold_valid", out_valid0, 1);
      chk("z_hold_in_ready", in_ready0, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("z_idle_busy", busy0, 0);

    // Subtract case, then start coinciding with DONE exit.
    c_init = ONE; sub = 1'b1; len = 8'd1; start0 = 1'b1;
    tick();
    start0 = 1'b0; a = ONE; b = ONE; in_valid0 = 1'b1;
    #1;
    chk("s_maf_sub", maf_sub0, 1);
    tick();
    in_valid0 = 1'b0;
    #1;
    chk("s_out_valid", out_valid0, 1);
    chk("s_result", result0, ZERO);
    out_ready = 1'b1; start0 = 1'b1; c_init = TWO; len = 8'd0; sub = 1'b0;
    tick();
    out_ready = 1'b0;
    #1;
    chk("s_exit_start_ignored", busy0, 0);
    tick();
    start0 = 1'b0;
    #1;
    chk("s_next_start_valid", out_valid0, 1);
    chk("s_next_start_result", result0, TWO);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // First MAF result forced to NaN over a three-pair run.
    c_init = ZERO; len = 8'd3; start0 = 1'b1;
    tick();
    start0 = 1'b0; force_en = 1'b1; force_val = QNAN; a = ONE; b = TWO; in_valid0 = 1'b1;
    #1;
    chk("n_in_ready_p1", in_ready0, 1);
    tick();
    force_val = TWO;
    #1;
    chk("n_acc_nan", maf_c0, QNAN);
    chk("n_in_ready_p2", in_ready0, 1);
    tick();
    force_val = SEVEN;
    #1;
    chk("n_in_ready_p3", in_ready0, 1);
    chk("n_out_valid_early", out_valid0, 0);
    tick();
    in_valid0 = 1'b0; force_en = 1'b0;
    #1;
    chk("n_out_valid", out_valid0, 1);
`ifdef MAF_SEQ_NAN_STICKY_EN
    chk("n_result", result0, QNAN);
`else
    chk("n_result", result0, SEVEN);
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("n_idle_busy", busy0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
